// File: rtl/s_protocol_adapter_pkg.sv
// Shared types and helpers for the egress protocol adapter: FSM state, the
// byte-group swap used on data and keep, and a parameter sanity check.
package s_protocol_adapter_pkg;

  localparam int MAX_BW  = 512;
  localparam int MAX_BWB = MAX_BW / 8;

  typedef enum logic {IDLE, IN_PKT} state_e;

  typedef struct packed {
    logic [MAX_BW-1:0]  data;
    logic [MAX_BWB-1:0] keep;
  } beat_t;

  function automatic bit cfg_ok(input int bw, input int bwb, input int gran);
    return (bw % 8 == 0) && (bw >= 32) && (bw <= MAX_BW) && (bwb == bw / 8) &&
           (gran >= 2) && ((gran & (gran - 1)) == 0) && (bwb % gran == 0);
  endfunction

  // Works on the widest bus; callers zero-pad and take the low BW bits.
  function automatic beat_t byte_group_swap(input logic [MAX_BW-1:0] data,
                                            input logic [MAX_BWB-1:0] keep,
                                            input int gran);
    beat_t r;
    int    src;
    for (int k = 0; k < MAX_BWB; k++) begin
      src                = (k / gran) * gran + (gran - 1 - (k % gran));
      r.data[k*8 +: 8]   = data[src*8 +: 8];
      r.keep[k]          = keep[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Main + skid register pair giving a fully registered AXI4-Stream stage with
// a registered upstream ready and 1 beat/cycle sustained throughput.
module axis_skid_buffer #(
  parameter int W = 37
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_valid_q, main_valid_d;
  logic [W-1:0] main_data_q,  main_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         ready_q;
  logic         accept, drain;

  assign accept = in_valid_i & ready_q;
  assign drain  = main_valid_q & out_ready_i;

  // ready_q tracks "skid empty", so skid is never written while it is full.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

endmodule

// File: rtl/s_protocol_adapter_egress_pipe.sv
// Egress adapter: per-packet byte-group swap/bypass on an AXI4-Stream,
// registered through a skid buffer, with beat/packet counters and keep check.
module s_protocol_adapter_egress_pipe
  import s_protocol_adapter_pkg::*;
#(
  parameter int BW   = 32,
  parameter int BWB  = BW / 8,
  parameter int GRAN = 4,
  parameter int CW   = 32
) (
  input  logic           clk_line,
  input  logic           rst_n,
  input  logic           swap_en,
  input  logic           stream_in_TVALID,
  output logic           stream_in_TREADY,
  input  logic [BW-1:0]  stream_in_TDATA,
  input  logic [BWB-1:0] stream_in_TKEEP,
  input  logic           stream_in_TLAST,
  output logic           stream_out_TVALID,
  input  logic           stream_out_TREADY,
  output logic [BW-1:0]  stream_out_TDATA,
  output logic [BWB-1:0] stream_out_TKEEP,
  output logic           stream_out_TLAST,
  output logic [CW-1:0]  pkt_cnt,
  output logic [CW-1:0]  beat_cnt,
  output logic           keep_err,
  input  logic           keep_err_clr
);

  localparam int PW = BW + BWB + 1;

  if (!cfg_ok(BW, BWB, GRAN)) begin : g_bad_cfg
    $error("s_protocol_adapter_egress_pipe: illegal BW/BWB/GRAN combination");
  end

  state_e             state_q;
  logic               mode_q;
  logic               swap_now, in_fire, keep_bad;
  logic [MAX_BW-1:0]  data_pad;
  logic [MAX_BWB-1:0] keep_pad;
  beat_t              swapped;
  logic [BW-1:0]      xform_data;
  logic [BWB-1:0]     xform_keep;
  logic [CW-1:0]      pkt_cnt_q, pkt_cnt_d, beat_cnt_q, beat_cnt_d;
  logic               keep_err_q, keep_err_d;
  logic [PW-1:0]      out_payload;

  assign in_fire  = stream_in_TVALID & stream_in_TREADY;
  // The first beat of a packet uses the live swap_en; later beats use the latch.
  assign swap_now = (state_q == IDLE) ? swap_en : mode_q;
  assign keep_bad = (!stream_in_TLAST && (stream_in_TKEEP != '1)) || (stream_in_TKEEP == '0);

  always_comb begin
    data_pad             = '0;
    keep_pad             = '0;
    data_pad[BW-1:0]     = stream_in_TDATA;
    keep_pad[BWB-1:0]    = stream_in_TKEEP;
    swapped              = byte_group_swap(data_pad, keep_pad, GRAN);
    xform_data           = swap_now ? swapped.data[BW-1:0]  : stream_in_TDATA;
    xform_keep           = swap_now ? swapped.keep[BWB-1:0] : stream_in_TKEEP;
  end

  if (BW < MAX_BW) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{swapped.data[MAX_BW-1:BW], swapped.keep[MAX_BWB-1:BWB]};
  end

  always_ff @(posedge clk_line or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
    end else if (in_fire) begin
      case (state_q)
        IDLE: begin
          mode_q <= swap_en;
          if (!stream_in_TLAST) state_q <= IN_PKT;
        end
        IN_PKT: begin
          if (stream_in_TLAST) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A new error in the same cycle as a clear keeps the flag set.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    keep_err_d = keep_err_q;
    if (in_fire) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (stream_in_TLAST) pkt_cnt_d = pkt_cnt_q + 1'b1;
    end
    if (keep_err_clr) keep_err_d = 1'b0;
    if (in_fire && keep_bad) keep_err_d = 1'b1;
  end

  always_ff @(posedge clk_line or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
      keep_err_q <= 1'b0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      keep_err_q <= keep_err_d;
    end
  end

  axis_skid_buffer #(.W(PW)) u_skid (
    .clk_i       (clk_line),
    .rst_ni      (rst_n),
    .in_valid_i  (stream_in_TVALID),
    .in_ready_o  (stream_in_TREADY),
    .in_data_i   ({stream_in_TLAST, xform_keep, xform_data}),
    .out_valid_o (stream_out_TVALID),
    .out_ready_i (stream_out_TREADY),
    .out_data_o  (out_payload)
  );

  assign {stream_out_TLAST, stream_out_TKEEP, stream_out_TDATA} = out_payload;
  assign pkt_cnt  = pkt_cnt_q;
  assign beat_cnt = beat_cnt_q;
  assign keep_err = keep_err_q;

endmodule
